read_adapter: RTL and testbench
===============================

Name: read_adapter

Overview:
- Load-side counterpart of the store path in the MEM stage.
- Accepts a load request (byte address, word size, signedness) and issues a word-aligned read to data memory.
- Waits the fixed memory latency, then extracts the addressed byte or halfword lane and sign- or zero-extends it to NB_DATA.
- Returns the result with a valid pulse; holds busy so the pipeline stalls MEM/WB while a load is in flight.

Parameters:
- NB_DATA, 32, data/word width.
- NB_ADDR, 32, byte address width.
- NB_TYPE, 3, word-size code width; codes are BYTE_WORD, HALF_WORD and COMPLETE_WORD from memory_constants.vh.
- MEM_LATENCY, 1, cycles from o_mem_rd_en to i_mem_rdata being valid; legal range 1..7.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  load request strobe.
- i_addr  in  NB_ADDR  byte address.
- i_word_size  in  NB_TYPE  access size code.
- i_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- o_mem_addr  out  NB_ADDR  word-aligned address, bits [1:0] = 0.
- o_mem_rd_en  out  1  one-cycle read strobe.
- i_mem_rdata  in  NB_DATA  memory read word.
- o_data  out  NB_DATA  extended load result.
- o_valid  out  1  one-cycle result strobe.
- o_busy  out  1  request in flight; new requests ignored.
- o_misaligned  out  1  one-cycle misalignment flag (feature only; tied 0 otherwise).

Behaviour:
- Reset (asynchronous, i_reset_n=0) forces all outputs and registers to 0: o_data, o_valid, o_busy, o_mem_rd_en, o_mem_addr, o_misaligned. FSM goes to IDLE.
- Reset asserted mid-operation abandons the load; no o_valid is produced after reset release.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - When i_req_valid=1, register the address offset (i_addr[1:0]), the size and i_unsigned.
  - Drive o_mem_addr = {i_addr[NB_ADDR-1:2], 2'b00} and o_mem_rd_en=1 for that one cycle.
  - Load the latency counter with MEM_LATENCY-1, set o_busy=1, go to WAIT.
- WAIT: decrement the counter each cycle. At count 0, capture i_mem_rdata and go to DONE.
- DONE:
  - Drive o_data (extracted and extended), o_valid=1 for exactly one cycle, clear o_busy, return to IDLE.
  - A new request is accepted in the cycle after DONE.
- Total latency from request to o_valid is MEM_LATENCY+1 cycles; back-to-back loads issue every MEM_LATENCY+2 cycles.
- i_req_valid while o_busy=1 is ignored; no queueing.
- Lane extraction:
  - Byte: lane = rdata[8*off+7 : 8*off].
  - Half: lane = rdata[16*off[1]+15 : 16*off[1]]; off[0] is ignored without the feature.
  - Word: full rdata.
- Extension: byte/half are sign-extended from the lane MSB when i_unsigned=0, zero-extended otherwise. i_unsigned has no effect on a word load.
- Undefined size code: the request still completes, with o_data=0 and o_valid=1.

Optional Feature:
- Macro: READ_ADAPTER_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned request = half with off[0]=1, or word with off!=0.
  - A misaligned request does not assert o_mem_rd_en and skips WAIT.
  - The next cycle gives o_misaligned=1, o_valid=1, o_data=0 (latency 1).
- Not defined: o_misaligned is tied 0, and low address bits are truncated to the access alignment.

Decomposition:
- memory_constants.vh (shared) holds the word-size codes and FSM state encodings (add RA_IDLE, RA_WAIT, RA_DONE).
- One combinational sub-module, load_extend: inputs rdata, off, size, unsigned; output extended data. It is instantiated once in the DONE path and unit-testable on its own.

Test Plan:
- Signed byte: addr 0x0000_0003, BYTE, i_unsigned=0, rdata 0x80AB_CDEF -> o_data 0xFFFF_FF80, o_valid exactly MEM_LATENCY+1 cycles after the request.
- Unsigned half: addr 0x0000_0002, HALF, i_unsigned=1, rdata 0x9234_5678 -> o_data 0x0000_9234; o_mem_addr 0x0000_0000.
- Word plus stall: addr 0x10, COMPLETE_WORD, rdata 0xDEAD_BEEF -> o_data 0xDEAD_BEEF. A second i_req_valid held while o_busy=1 produces no extra o_mem_rd_en; it is accepted only the cycle after o_valid.
- Reset mid-load: assert i_reset_n=0 during WAIT -> all outputs 0 immediately; o_valid never asserts for that load.
- Run with MEM_LATENCY=1 and MEM_LATENCY=3 -> o_valid at cycles +2 and +4 respectively.
- Feature on: HALF at addr 0x1 -> o_misaligned=1, o_valid=1, o_data=0 the next cycle, no o_mem_rd_en. Feature off: same request returns the half at offset 0.

Source files
------------

// File: rtl/read_adapter_pkg.sv
// Shared constants for the MEM-stage load path: access-size codes, adapter
// FSM states and a misalignment helper.  The helper is only consulted when
// READ_ADAPTER_MISALIGN_TRAP_EN is defined.
package read_adapter_pkg;

   // Access-size codes carried from decode into the MEM stage.
   localparam logic [2:0] BYTE_WORD     = 3'b001;
   localparam logic [2:0] HALF_WORD     = 3'b010;
   localparam logic [2:0] COMPLETE_WORD = 3'b011;

   // Wide enough for MEM_LATENCY-1 with MEM_LATENCY up to 7.
   localparam int RA_CNT_W = 3;

   typedef enum logic [1:0] {
      RA_IDLE = 2'd0,
      RA_WAIT = 2'd1,
      RA_DONE = 2'd2
   } ra_state_e;

   // A half must sit on an even byte and a word on a word boundary.
   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      if (size == HALF_WORD && off[0]) begin
         mis = 1'b1;
      end
      if (size == COMPLETE_WORD && off != 2'b00) begin
         mis = 1'b1;
      end
      return mis;
   endfunction

endpackage

// File: rtl/read_adapter_if.sv
// Bundle of the load request, data-memory read port and result signals of
// the read adapter.  The slave modport is the adapter's view; the master
// modport is the view of whoever drives requests and models the memory.
interface read_adapter_if #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 32,
   parameter int NB_TYPE = 3
);

   logic               i_req_valid;
   logic [NB_ADDR-1:0] i_addr;
   logic [NB_TYPE-1:0] i_word_size;
   logic               i_unsigned;
   logic [NB_ADDR-1:0] o_mem_addr;
   logic               o_mem_rd_en;
   logic [NB_DATA-1:0] i_mem_rdata;
   logic [NB_DATA-1:0] o_data;
   logic               o_valid;
   logic               o_busy;
   logic               o_misaligned;

   modport slave (
      input  i_req_valid, i_addr, i_word_size, i_unsigned, i_mem_rdata,
      output o_mem_addr, o_mem_rd_en, o_data, o_valid, o_busy, o_misaligned
   );

   modport master (
      output i_req_valid, i_addr, i_word_size, i_unsigned, i_mem_rdata,
      input  o_mem_addr, o_mem_rd_en, o_data, o_valid, o_busy, o_misaligned
   );

endinterface

// File: rtl/read_adapter_load_extend.sv
// Picks the addressed byte/halfword lane out of a memory word and sign- or
// zero-extends it.  Half lanes use only off[1] and word loads ignore the
// offset, so unaligned low bits are simply truncated.  Unknown size codes
// give zero.
module load_extend
   import read_adapter_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_TYPE = 3
) (
   input  logic [NB_DATA-1:0] i_rdata,
   input  logic [1:0]         i_off,
   input  logic [NB_TYPE-1:0] i_size,
   input  logic               i_unsigned,
   output logic [NB_DATA-1:0] o_data
);

   logic [7:0]  byteLane;
   logic [15:0] halfLane;
   logic        byteFill;
   logic        halfFill;

   // Lane selection and extension, purely combinational.
   always_comb begin
      byteLane = i_rdata[{i_off, 3'b000} +: 8];
      halfLane = i_rdata[{i_off[1], 4'b0000} +: 16];
      byteFill = byteLane[7] & ~i_unsigned;
      halfFill = halfLane[15] & ~i_unsigned;
      o_data   = '0;
      case (i_size)
         BYTE_WORD:     o_data = {{(NB_DATA-8){byteFill}}, byteLane};
         HALF_WORD:     o_data = {{(NB_DATA-16){halfFill}}, halfLane};
         COMPLETE_WORD: o_data = i_rdata;
         default:       o_data = '0;
      endcase
   end

endmodule

// File: rtl/read_adapter.sv
// MEM-stage load adapter: issues a word-aligned read, waits MEM_LATENCY
// cycles, then returns the extracted and extended lane with a one-cycle
// o_valid.  o_busy is high while the read is outstanding.
// Optional macro READ_ADAPTER_MISALIGN_TRAP_EN turns misaligned half/word
// requests into an immediate o_misaligned result without a memory read.
module read_adapter
   import read_adapter_pkg::*;
#(
   parameter int NB_DATA     = 32,
   parameter int NB_ADDR     = 32,
   parameter int NB_TYPE     = 3,
   parameter int MEM_LATENCY = 1
) (
   input logic           i_clk,
   input logic           i_reset_n,
   read_adapter_if.slave bus
);

   localparam logic [RA_CNT_W-1:0] CNT_INIT = RA_CNT_W'(MEM_LATENCY - 1);

   ra_state_e             state_q, state_d;
   logic [RA_CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]            off_q, off_d;
   logic [NB_TYPE-1:0]    size_q, size_d;
   logic                  uns_q, uns_d;
   logic [NB_DATA-1:0]    rdata_q, rdata_d;
   logic                  misal_q, misal_d;

   logic                  accept;
   logic                  misReq;
   logic [NB_DATA-1:0]    extData;
   logic [NB_ADDR-1:0]    memAddr;
   logic                  memRdEn;
   logic [NB_DATA-1:0]    dataOut;
   logic                  validOut;
   logic                  busyOut;
   logic                  misOut;

   load_extend #(
      .NB_DATA (NB_DATA),
      .NB_TYPE (NB_TYPE)
   ) u_load_extend (
      .i_rdata    (rdata_q),
      .i_off      (off_q),
      .i_size     (size_q),
      .i_unsigned (uns_q),
      .o_data     (extData)
   );

   // Request acceptance and misalignment classification of the incoming request.
   always_comb begin
      accept = (state_q == RA_IDLE) && bus.i_req_valid && i_reset_n;
`ifdef READ_ADAPTER_MISALIGN_TRAP_EN
      misReq = is_misaligned(3'(bus.i_word_size), bus.i_addr[1:0]);
`else
      misReq = 1'b0;
`endif
   end

   // State register and captured request/response; reset abandons any load.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= RA_IDLE;
         cnt_q   <= '0;
         off_q   <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         rdata_q <= '0;
         misal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         off_q   <= off_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         rdata_q <= rdata_d;
         misal_q <= misal_d;
      end
   end

   // Next-state logic and outputs; outputs are decoded from state so they drop with reset.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      off_d    = off_q;
      size_d   = size_q;
      uns_d    = uns_q;
      rdata_d  = rdata_q;
      misal_d  = misal_q;
      memRdEn  = 1'b0;
      memAddr  = '0;
      dataOut  = '0;
      validOut = 1'b0;
      busyOut  = 1'b0;
      misOut   = 1'b0;
      case (state_q)
         RA_IDLE: begin
            if (accept) begin
               off_d   = bus.i_addr[1:0];
               size_d  = bus.i_word_size;
               uns_d   = bus.i_unsigned;
               cnt_d   = CNT_INIT;
               misal_d = misReq;
               if (misReq) begin
                  state_d = RA_DONE;
               end else begin
                  state_d = RA_WAIT;
                  memRdEn = 1'b1;
                  memAddr = {bus.i_addr[NB_ADDR-1:2], 2'b00};
               end
            end
         end
         RA_WAIT: begin
            busyOut = 1'b1;
            if (cnt_q == '0) begin
               rdata_d = bus.i_mem_rdata;
               state_d = RA_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RA_DONE: begin
            validOut = 1'b1;
            misOut   = misal_q;
            dataOut  = misal_q ? '0 : extData;
            state_d  = RA_IDLE;
         end
         default: begin
            state_d = RA_IDLE;
         end
      endcase
   end

   assign bus.o_mem_addr   = memAddr;
   assign bus.o_mem_rd_en  = memRdEn;
   assign bus.o_data       = dataOut;
   assign bus.o_valid      = validOut;
   assign bus.o_busy       = busyOut;
   assign bus.o_misaligned = misOut;

endmodule

// File: tb/tb_read_adapter.sv
// Scoreboard bench for read_adapter.  Two adapters (MEM_LATENCY 1 and 3)
// see the same requests; each has its own delayed memory model and monitor.
// Honours READ_ADAPTER_MISALIGN_TRAP_EN for the misaligned-half vector.
module tb_read_adapter;
   import read_adapter_pkg::*;

   typedef struct {
      logic [31:0] data;
      int          cycle;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetN;
   int          cyc = 0;
   logic        reqValid;
   logic [31:0] reqAddr;
   logic [2:0]  reqSize;
   logic        reqUns;

   int          checks = 0;
   int          failures = 0;
   int          rdA = 0;
   int          rdB = 0;
   exp_t        qA[$];
   exp_t        qB[$];
   exp_t        eA;
   exp_t        eB;

   logic [31:0] mem [logic [29:0]];
   logic [31:0] lineA;
   logic [31:0] lineB [3];

   read_adapter_if #(.NB_DATA(32), .NB_ADDR(32), .NB_TYPE(3)) busA ();
   read_adapter_if #(.NB_DATA(32), .NB_ADDR(32), .NB_TYPE(3)) busB ();

   read_adapter #(.NB_DATA(32), .NB_ADDR(32), .NB_TYPE(3), .MEM_LATENCY(1)) dutA (
      .i_clk     (clk),
      .i_reset_n (resetN),
      .bus       (busA.slave)
   );

   read_adapter #(.NB_DATA(32), .NB_ADDR(32), .NB_TYPE(3), .MEM_LATENCY(3)) dutB (
      .i_clk     (clk),
      .i_reset_n (resetN),
      .bus       (busB.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign busA.i_req_valid = reqValid;
   assign busA.i_addr      = reqAddr;
   assign busA.i_word_size = reqSize;
   assign busA.i_unsigned  = reqUns;
   assign busB.i_req_valid = reqValid;
   assign busB.i_addr      = reqAddr;
   assign busB.i_word_size = reqSize;
   assign busB.i_unsigned  = reqUns;

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (mem.exists(a[31:2])) return mem[a[31:2]];
      return 32'hBAD1_1111;
   endfunction

   // Memory models: read data appears exactly MEM_LATENCY cycles after the strobe, junk otherwise.
   always @(posedge clk) begin
      lineA    <= busA.o_mem_rd_en ? memRead(busA.o_mem_addr) : 32'hBAD0_0000;
      lineB[0] <= busB.o_mem_rd_en ? memRead(busB.o_mem_addr) : 32'hBAD0_0000;
      lineB[1] <= lineB[0];
      lineB[2] <= lineB[1];
   end
   assign busA.i_mem_rdata = lineA;
   assign busB.i_mem_rdata = lineB[2];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Monitor for the latency-1 adapter.
   always @(negedge clk) begin
      if (busA.o_mem_rd_en) rdA++;
      if (busA.o_valid) begin
         if (qA.size() == 0) begin
            checkOutput("A unexpected o_valid", 32'd1, 32'd0);
         end else begin
            eA = qA.pop_front();
            checkOutput("A o_data", busA.o_data, eA.data);
            checkOutput("A valid cycle", 32'(cyc), 32'(eA.cycle));
            checkOutput("A o_misaligned", {31'd0, busA.o_misaligned}, {31'd0, eA.mis});
         end
      end
   end

   // Monitor for the latency-3 adapter.
   always @(negedge clk) begin
      if (busB.o_mem_rd_en) rdB++;
      if (busB.o_valid) begin
         if (qB.size() == 0) begin
            checkOutput("B unexpected o_valid", 32'd1, 32'd0);
         end else begin
            eB = qB.pop_front();
            checkOutput("B o_data", busB.o_data, eB.data);
            checkOutput("B valid cycle", 32'(cyc), 32'(eB.cycle));
            checkOutput("B o_misaligned", {31'd0, busB.o_misaligned}, {31'd0, eB.mis});
         end
      end
   end

   task automatic waitDone();
      for (int i = 0; i < 25 && (qA.size() != 0 || qB.size() != 0); i++) begin
         @(posedge clk);
      end
      #1;
      if (qA.size() != 0 || qB.size() != 0) begin
         checkOutput("result timeout", 32'(qA.size() + qB.size()), 32'd0);
         qA.delete();
         qB.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // One request, called just after a rising edge; mis selects the trap response.
   task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] size, input logic uns,
                                input logic [31:0] word, input logic [31:0] expData, input logic mis);
      int k;
      mem[addr[31:2]] = word;
      k = cyc;
      if (mis) begin
         qA.push_back('{data: 32'd0, cycle: k + 1, mis: 1'b1});
         qB.push_back('{data: 32'd0, cycle: k + 1, mis: 1'b1});
      end else begin
         qA.push_back('{data: expData, cycle: k + 2, mis: 1'b0});
         qB.push_back('{data: expData, cycle: k + 4, mis: 1'b0});
      end
      reqValid = 1'b1;
      reqAddr  = addr;
      reqSize  = size;
      reqUns   = uns;
      @(negedge clk);
      checkOutput("A o_mem_rd_en", {31'd0, busA.o_mem_rd_en}, {31'd0, ~mis});
      checkOutput("B o_mem_rd_en", {31'd0, busB.o_mem_rd_en}, {31'd0, ~mis});
      if (!mis) checkOutput("A o_mem_addr", busA.o_mem_addr, {addr[31:2], 2'b00});
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      if (!mis) begin
         checkOutput("A o_busy in WAIT", {31'd0, busA.o_busy}, 32'd1);
         checkOutput("B o_busy in WAIT", {31'd0, busB.o_busy}, 32'd1);
      end
      waitDone();
   endtask

   // Request held high across a whole load: the second copy is taken only after o_valid.
   task automatic stallTest();
      int k;
      int rdA0;
      int rdB0;
      mem[30'h4] = 32'hDEAD_BEEF;
      mem[30'h5] = 32'hCAFE_F00D;
      k    = cyc;
      rdA0 = rdA;
      rdB0 = rdB;
      qA.push_back('{data: 32'hDEAD_BEEF, cycle: k + 2, mis: 1'b0});
      qA.push_back('{data: 32'hCAFE_F00D, cycle: k + 5, mis: 1'b0});
      qB.push_back('{data: 32'hDEAD_BEEF, cycle: k + 4, mis: 1'b0});
      qB.push_back('{data: 32'hCAFE_F00D, cycle: k + 9, mis: 1'b0});
      reqValid = 1'b1;
      reqAddr  = 32'h0000_0010;
      reqSize  = COMPLETE_WORD;
      reqUns   = 1'b0;
      @(posedge clk);
      #1;
      reqAddr = 32'h0000_0014;
      while (cyc <= k + 5) begin
         @(posedge clk);
         #1;
      end
      reqValid = 1'b0;
      waitDone();
      checkOutput("A reads during stall", 32'(rdA - rdA0), 32'd2);
      checkOutput("B reads during stall", 32'(rdB - rdB0), 32'd2);
   endtask

   // Reset during WAIT: outputs drop at once and the load never completes.
   task automatic resetTest();
      mem[30'h8] = 32'h1234_5678;
      reqValid = 1'b1;
      reqAddr  = 32'h0000_0020;
      reqSize  = COMPLETE_WORD;
      reqUns   = 1'b0;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      checkOutput("A busy before reset", {31'd0, busA.o_busy}, 32'd1);
      resetN = 1'b0;
      #1;
      checkOutput("A o_busy in reset", {31'd0, busA.o_busy}, 32'd0);
      checkOutput("B o_busy in reset", {31'd0, busB.o_busy}, 32'd0);
      checkOutput("B o_valid in reset", {31'd0, busB.o_valid}, 32'd0);
      checkOutput("B o_data in reset", busB.o_data, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      resetN = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("A o_busy after abandon", {31'd0, busA.o_busy}, 32'd0);
      checkOutput("B o_busy after abandon", {31'd0, busB.o_busy}, 32'd0);
   endtask

   initial begin
      resetN   = 1'b0;
      reqValid = 1'b0;
      reqAddr  = 32'd0;
      reqSize  = BYTE_WORD;
      reqUns   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset o_data", busA.o_data, 32'd0);
      checkOutput("reset o_valid", {31'd0, busA.o_valid}, 32'd0);
      checkOutput("reset o_busy", {31'd0, busA.o_busy}, 32'd0);
      checkOutput("reset o_mem_rd_en", {31'd0, busA.o_mem_rd_en}, 32'd0);
      checkOutput("reset o_mem_addr", busA.o_mem_addr, 32'd0);
      checkOutput("reset o_misaligned", {31'd0, busA.o_misaligned}, 32'd0);
      resetN = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(32'h0000_0003, BYTE_WORD,     1'b0, 32'h80AB_CDEF, 32'hFFFF_FF80, 1'b0);
      applyStimulus(32'h0000_0002, HALF_WORD,     1'b1, 32'h9234_5678, 32'h0000_9234, 1'b0);
      applyStimulus(32'h0000_0006, HALF_WORD,     1'b0, 32'h9234_5678, 32'hFFFF_9234, 1'b0);
      applyStimulus(32'h0000_0009, BYTE_WORD,     1'b1, 32'h1122_8344, 32'h0000_0083, 1'b0);
      applyStimulus(32'h0000_000D, BYTE_WORD,     1'b0, 32'h1122_8344, 32'hFFFF_FF83, 1'b0);
      applyStimulus(32'h0000_0008, BYTE_WORD,     1'b0, 32'h1122_8344, 32'h0000_0044, 1'b0);
      applyStimulus(32'h0000_0020, COMPLETE_WORD, 1'b1, 32'h8000_0001, 32'h8000_0001, 1'b0);
      applyStimulus(32'h0000_0024, 3'b111,        1'b0, 32'h5555_AAAA, 32'h0000_0000, 1'b0);
      stallTest();
      resetTest();
`ifdef READ_ADAPTER_MISALIGN_TRAP_EN
      applyStimulus(32'h0000_0001, HALF_WORD,     1'b0, 32'h1234_ABCD, 32'h0000_0000, 1'b1);
`else
      applyStimulus(32'h0000_0001, HALF_WORD,     1'b0, 32'h1234_ABCD, 32'hFFFF_ABCD, 1'b0);
`endif
      applyStimulus(32'h0000_0030, COMPLETE_WORD, 1'b0, 32'h0F0E_0D0C, 32'h0F0E_0D0C, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound so the bench cannot hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog");
   end

endmodule
